// File: rtl/gcd_if.sv
// Operand/result bundle for gcd_engine: start request with operands in,
// status, result and cycle count out.
// Handshake: go_i is a request sampled only while busy_o=0 (the cycle done_o
// is high counts as not busy); the operands ride with it. A request seen
// while busy_o=1 is dropped, not queued. done_o pulses once per accepted
// request and the result fields stay valid until the next done_o.
interface gcd_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
);
    logic             go_i;
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] y_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] d_o;
    logic             zero_o;
    logic [CW-1:0]    cyc_o;
    logic [1:0]       state_o;

    modport master (
        output go_i, x_i, y_i,
        input  busy_o, done_o, d_o, zero_o, cyc_o, state_o
    );

    modport slave (
        input  go_i, x_i, y_i,
        output busy_o, done_o, d_o, zero_o, cyc_o, state_o
    );
endinterface

// File: rtl/gcd_engine.sv
// Binary (Stein) gcd engine: shift/subtract only, one step per clock,
// with a saturating count of the cycles each computation took.
module gcd_engine #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input logic  clk,
    input logic  rst,
    gcd_if.slave bus
);
    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        ITER   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, y_q;
    logic [KW-1:0]    k_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] d_q;
    logic             zero_q;
    logic [CW-1:0]    cyc_q;
    logic             done_q;
    logic             op_zero;
    logic             both_even;

    assign op_zero   = (bus.x_i == '0) || (bus.y_i == '0);
    assign both_even = !x_q[0] && !y_q[0];
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.go_i) state_d = op_zero ? FINISH : REDUCE;
            end
            REDUCE: begin
                if (!both_even) state_d = ITER;
            end
            ITER: begin
                // Equality is only tested once both values are odd.
                if (x_q[0] && y_q[0] && (x_q == y_q)) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            d_q    <= '0;
            zero_q <= 1'b0;
            cyc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.go_i) begin
                        k_q   <= '0;
                        cnt_q <= '0;
                        if (op_zero) begin
                            x_q <= bus.x_i | bus.y_i;
                            y_q <= '0;
                        end else begin
                            x_q <= bus.x_i;
                            y_q <= bus.y_i;
                        end
                    end
                end
                REDUCE: begin
                    cnt_q <= cnt_inc;
                    if (both_even) begin
                        x_q <= x_q >> 1;
                        y_q <= y_q >> 1;
                        k_q <= k_q + 1'b1;
                    end
                end
                ITER: begin
                    cnt_q <= cnt_inc;
                    if (!x_q[0])            x_q <= x_q >> 1;
                    else if (!y_q[0])       y_q <= y_q >> 1;
                    else if (x_q == y_q)    x_q <= x_q;
                    // Both odd here, so the difference is even and non-negative.
                    else if (x_q > y_q)     x_q <= (x_q - y_q) >> 1;
                    else                    y_q <= (y_q - x_q) >> 1;
                end
                FINISH: begin
                    d_q    <= x_q << k_q;
                    zero_q <= (x_q == '0);
                    cyc_q  <= cnt_inc;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o  = (state_q != IDLE);
    assign bus.done_o  = done_q;
    assign bus.d_o     = d_q;
    assign bus.zero_o  = zero_q;
    assign bus.cyc_o   = cyc_q;
    assign bus.state_o = state_q;
endmodule
